// File: rtl/deck_shuffler.sv
// Card deck shuffler: rebuilds an identity deck, Fisher-Yates shuffles it with a
// 16-bit Galois LFSR, then deals one card index per Deal request.
module deck_shuffler #(
  parameter int N_CARDS = 52,
  parameter int ADDR_W  = 6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [15:0]       Seed,
  input  logic              Deal,
  output logic [ADDR_W-1:0] Card,
  output logic              Card_valid,
  output logic              Busy,
  output logic              Ready,
  output logic              Empty,
  output logic [ADDR_W:0]   Remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SHUF = 2'd2,
    DEAL = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(N_CARDS - 1);
  localparam logic [ADDR_W-1:0] FIRST_SWAP   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   DECK_SIZE    = (ADDR_W + 1)'(N_CARDS);
  localparam logic [15:0]       DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0]       TAP_MASK     = 16'hB400;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] deck [N_CARDS];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   ptr;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_step;
  logic [15:0]       swap_mod;
  logic [ADDR_W-1:0] swap_idx;
  logic [15:0]       seed_load;
  logic              start_ok;
  logic              deal_ok;

  // NOTE: every signal assigned in an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAP_MASK : 16'h0000);
    swap_mod  = 16'(idx) + 16'd1;
    swap_idx  = ADDR_W'(lfsr % swap_mod);
    seed_load = (Seed == 16'h0000) ? DEFAULT_SEED : Seed;
    start_ok  = Start && ((state == IDLE) || (state == DEAL));
    // Start has priority over Deal in the same DEAL cycle.
    deal_ok   = Deal && !Start && (state == DEAL) && (ptr < DECK_SIZE);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (Start) state_next = INIT;
      INIT: if (idx == LAST_IDX) state_next = SHUF;
      SHUF: if (idx == FIRST_SWAP) state_next = DEAL;
      DEAL: if (Start) state_next = INIT;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; the in-place swap below relies on exactly that.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idx        <= '0;
      ptr        <= '0;
      lfsr       <= DEFAULT_SEED;
      Card       <= '0;
      Card_valid <= 1'b0;
    end else begin
      Card_valid <= 1'b0;
      if (start_ok) begin
        idx  <= '0;
        ptr  <= '0;
        lfsr <= seed_load;
      end else begin
        case (state)
          INIT: begin
            lfsr <= lfsr_step;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
          SHUF: begin
            lfsr <= lfsr_step;
            idx  <= idx - 1'b1;
          end
          DEAL: begin
            if (deal_ok) begin
              Card       <= deck[ptr[ADDR_W-1:0]];
              Card_valid <= 1'b1;
              ptr        <= ptr + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the deck is plain storage with no reset; it is always rebuilt during INIT
  // before any card is read, so clearing it would only cost reset fan-out.
  always_ff @(posedge Clock) begin
    if (state == INIT) begin
      deck[idx] <= idx;
    end else if (state == SHUF) begin
      deck[idx]      <= deck[swap_idx];
      deck[swap_idx] <= deck[idx];
    end
  end

  always_comb begin
    Busy      = (state == INIT) || (state == SHUF);
    Ready     = (state == DEAL);
    Empty     = (state == DEAL) && (ptr == DECK_SIZE);
    Remaining = (state == DEAL) ? (DECK_SIZE - ptr) : '0;
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// Self-checking bench for deck_shuffler: a 52-card and an 8-card instance, a
// Fisher-Yates reference model and a scoreboard monitor on Card_valid.
module tb_deck_shuffler;

  logic        clk;
  logic        rst;
  logic        start_s [2];
  logic        deal_s  [2];
  logic [15:0] seed_s  [2];

  wire  [5:0]  card_a;
  wire  [6:0]  rem_a;
  wire         cv_a, busy_a, ready_a, empty_a;
  wire  [2:0]  card_b;
  wire  [3:0]  rem_b;
  wire         cv_b, busy_b, ready_b, empty_b;

  int   card_v  [2];
  int   rem_v   [2];
  logic cv_v    [2];
  logic busy_v  [2];
  logic ready_v [2];
  logic empty_v [2];

  int total = 0;
  int bad   = 0;
  int dealt [2];
  int mseq  [64];
  int runs  [8][64];
  int exp_q0 [$];
  int exp_q1 [$];
  int got_q0 [$];
  int got_q1 [$];

  deck_shuffler #(.N_CARDS(52), .ADDR_W(6)) dut_a (
    .Clock(clk), .Reset(rst), .Start(start_s[0]), .Seed(seed_s[0]), .Deal(deal_s[0]),
    .Card(card_a), .Card_valid(cv_a), .Busy(busy_a), .Ready(ready_a), .Empty(empty_a),
    .Remaining(rem_a)
  );

  deck_shuffler #(.N_CARDS(8), .ADDR_W(3)) dut_b (
    .Clock(clk), .Reset(rst), .Start(start_s[1]), .Seed(seed_s[1]), .Deal(deal_s[1]),
    .Card(card_b), .Card_valid(cv_b), .Busy(busy_b), .Ready(ready_b), .Empty(empty_b),
    .Remaining(rem_b)
  );

  always_comb begin
    card_v[0]  = int'(card_a);  card_v[1]  = int'(card_b);
    rem_v[0]   = int'(rem_a);   rem_v[1]   = int'(rem_b);
    cv_v[0]    = cv_a;          cv_v[1]    = cv_b;
    busy_v[0]  = busy_a;        busy_v[1]  = busy_b;
    ready_v[0] = ready_a;       ready_v[1] = ready_b;
    empty_v[0] = empty_a;       empty_v[1] = empty_b;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ncards(input int d);
    return (d == 0) ? 52 : 8;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference: identity deck, N warm-up steps, then a downward Fisher-Yates pass
  // drawing one LFSR value per position.
  task automatic build_model(input int n, input logic [15:0] sd);
    logic [15:0] l;
    int deck [64];
    int j, tmp;
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int k = 0; k < n; k++) begin
      deck[k] = k;
      l = lfsr_next(l);
    end
    for (int i = n - 1; i >= 1; i--) begin
      j = int'(l) % (i + 1);
      tmp = deck[i]; deck[i] = deck[j]; deck[j] = tmp;
      l = lfsr_next(l);
    end
    for (int k = 0; k < n; k++) mseq[k] = deck[k];
  endtask

  task automatic push_exp(input int d, input int v);
    if (d == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endtask

  function automatic int exp_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic int got_size(input int d);
    return (d == 0) ? got_q0.size() : got_q1.size();
  endfunction

  function automatic int got_at(input int d, input int k);
    if (k >= got_size(d)) return -1;
    return (d == 0) ? got_q0[k] : got_q1[k];
  endfunction

  task automatic clear_got(input int d);
    if (d == 0) got_q0.delete(); else got_q1.delete();
  endtask

  // Scoreboard monitors: every Card_valid pulse must match the next queued card.
  int e0, e1;
  always @(negedge clk) begin
    if (cv_v[0]) begin
      if (exp_q0.size() == 0) check("spurious_card_a", int'(cv_v[0]), 0);
      else begin
        e0 = exp_q0.pop_front();
        check("card_a", card_v[0], e0);
        got_q0.push_back(card_v[0]);
      end
    end
  end
  always @(negedge clk) begin
    if (cv_v[1]) begin
      if (exp_q1.size() == 0) check("spurious_card_b", int'(cv_v[1]), 0);
      else begin
        e1 = exp_q1.pop_front();
        check("card_b", card_v[1], e1);
        got_q1.push_back(card_v[1]);
      end
    end
  end

  // Called at a negedge; returns at the negedge where Busy has dropped.
  task automatic shuffle(input int d, input logic [15:0] sd, input int mid_start,
                         input bit with_deal);
    int n, busy_n;
    n = ncards(d);
    build_model(n, sd);
    start_s[d] = 1'b1;
    seed_s[d]  = sd;
    deal_s[d]  = with_deal;
    @(negedge clk);
    start_s[d] = 1'b0;
    deal_s[d]  = 1'b0;
    dealt[d]   = 0;
    clear_got(d);
    check("no_card_on_start", int'(cv_v[d]), 0);
    check("busy_rises", int'(busy_v[d]), 1);
    busy_n = 0;
    while (busy_v[d] && busy_n < 1000) begin
      busy_n++;
      start_s[d] = (busy_n == mid_start);
      if (busy_n == mid_start) seed_s[d] = 16'h9999;
      @(negedge clk);
    end
    start_s[d] = 1'b0;
    check("busy_cycles", busy_n, 2 * n - 1);
    check("ready_after_busy", int'(ready_v[d]), 1);
    check("remaining_full", rem_v[d], n);
  endtask

  task automatic deal_cards(input int d, input int count);
    int guard, n;
    guard = 0;
    n = ncards(d);
    while (dealt[d] < count && guard < 5000) begin
      check("remaining", rem_v[d], n - dealt[d]);
      check("not_empty", int'(empty_v[d]), 0);
      if ($urandom_range(0, 3) != 0) begin
        deal_s[d] = 1'b1;
        push_exp(d, mseq[dealt[d]]);
        dealt[d]++;
      end else begin
        deal_s[d] = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    deal_s[d] = 1'b0;
    check("deal_count", dealt[d], count);
  endtask

  task automatic finish_deck(input int d);
    int n, missing, v;
    int seen [64];
    n = ncards(d);
    check("remaining_zero", rem_v[d], 0);
    check("empty_set", int'(empty_v[d]), 1);
    deal_s[d] = 1'b1;
    @(negedge clk);
    deal_s[d] = 1'b0;
    check("deal_when_empty", int'(cv_v[d]), 0);
    check("card_holds", card_v[d], mseq[n-1]);
    check("empty_stays", int'(empty_v[d]), 1);
    @(negedge clk);
    check("scoreboard_drained", exp_size(d), 0);
    check("cards_received", got_size(d), n);
    for (int k = 0; k < 64; k++) seen[k] = 0;
    for (int k = 0; k < got_size(d); k++) begin
      v = got_at(d, k);
      if (v >= 0 && v < n) seen[v]++;
    end
    missing = 0;
    for (int k = 0; k < n; k++) if (seen[k] != 1) missing++;
    check("permutation", missing, 0);
  endtask

  task automatic save_run(input int d, input int r);
    for (int k = 0; k < 64; k++) runs[r][k] = (k < ncards(d)) ? got_at(d, k) : -1;
  endtask

  function automatic int run_diffs(input int a, input int b);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 64; k++) if (runs[a][k] != runs[b][k]) cnt++;
    return cnt;
  endfunction

  int pulses;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      deal_s[d]  = 1'b0;
      seed_s[d]  = 16'h0000;
      dealt[d]   = 0;
    end
    #7;
    for (int d = 0; d < 2; d++) begin
      check("reset_busy",  int'(busy_v[d]),  0);
      check("reset_ready", int'(ready_v[d]), 0);
      check("reset_empty", int'(empty_v[d]), 0);
      check("reset_rem",   rem_v[d],         0);
      check("reset_cv",    int'(cv_v[d]),    0);
      check("reset_card",  card_v[d],        0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Deal requests in IDLE must be ignored.
    deal_s[0] = 1'b1;
    deal_s[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cv_v[0] || cv_v[1]) pulses++;
    end
    deal_s[0] = 1'b0;
    deal_s[1] = 1'b0;
    check("idle_deal_pulses", pulses, 0);
    check("idle_not_ready", int'(ready_v[0]), 0);

    // Baseline shuffle, full deal, Empty behaviour.
    shuffle(0, 16'h1234, -1, 1'b0);
    deal_cards(0, 52);
    finish_deck(0);
    save_run(0, 0);

    // Same seed with a Start pulse mid-SHUF: ignored, identical sequence.
    shuffle(0, 16'h1234, 70, 1'b0);
    deal_cards(0, 52);
    finish_deck(0);
    save_run(0, 1);
    check("repeat_seed_identical", run_diffs(0, 1), 0);

    // Zero seed falls back to 0xACE1; a neighbouring seed gives another order.
    shuffle(0, 16'h0000, -1, 1'b0);
    deal_cards(0, 52);
    finish_deck(0);
    save_run(0, 2);
    shuffle(0, 16'hACE1, -1, 1'b0);
    deal_cards(0, 52);
    finish_deck(0);
    save_run(0, 3);
    check("zero_seed_is_ace1", run_diffs(2, 3), 0);
    shuffle(0, 16'h1235, -1, 1'b0);
    deal_cards(0, 52);
    finish_deck(0);
    save_run(0, 4);
    check("seed_1235_differs", int'(run_diffs(0, 4) > 0), 1);

    // Partial deal, then Start and Deal together: Start wins.
    shuffle(0, 16'h5678, -1, 1'b0);
    deal_cards(0, 5);
    shuffle(0, 16'h1234, -1, 1'b1);
    deal_cards(0, 52);
    finish_deck(0);
    save_run(0, 5);
    check("reshuffle_matches_baseline", run_diffs(0, 5), 0);

    // Asynchronous reset at SHUF cycle 40 aborts the shuffle.
    start_s[0] = 1'b1;
    seed_s[0]  = 16'h1234;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (91) @(negedge clk);
    check("busy_before_abort", int'(busy_v[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",  int'(busy_v[0]),  0);
    check("abort_ready", int'(ready_v[0]), 0);
    check("abort_rem",   rem_v[0],         0);
    check("abort_cv",    int'(cv_v[0]),    0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_abort", int'(busy_v[0]), 0);
    shuffle(0, 16'h1234, -1, 1'b0);
    deal_cards(0, 52);
    finish_deck(0);
    save_run(0, 6);
    check("after_abort_matches_baseline", run_diffs(0, 6), 0);

    // Small deck instance.
    shuffle(1, 16'h0001, -1, 1'b0);
    deal_cards(1, 8);
    finish_deck(1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
